// File: rtl/issue_scoreboard.sv
// In-order issue controller: tracks pending register writes over the 64-entry int/float space
// and holds each decoded instruction until it is hazard-free. Optional macro: SCOREBOARD_BYPASS_EN.
module issue_scoreboard #(
  parameter int MAX_OUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_rs1,
  input  logic [5:0] in_rs2,
  input  logic [5:0] in_rd,
  input  logic       in_fpu,
  input  logic       in_mem,
  input  logic       in_io,
  input  logic       fpu_busy,
  input  logic       mem_busy,
  input  logic       wb_valid,
  input  logic [5:0] wb_addr,
  input  logic       flush,
  output logic       issue,
  output logic [3:0] outstanding,
  output logic       draining,
  output logic       wb_err
);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t      r_state;
  logic [63:0] r_busy;
  logic [3:0]  r_outstanding;
  logic        r_wbErr;

  logic        w_wbHit;
  logic        w_wbMiss;
  logic        w_setEn;
  logic [63:0] w_clrMask;
  logic [63:0] w_setMask;
  logic [63:0] w_hazBusy;
  logic [3:0]  w_postWb;
  logic        w_raw;
  logic        w_waw;
  logic        w_struct;
  logic        w_cap;
  logic        w_goDrain;
  logic        w_stateOk;

  assign w_wbHit   = wb_valid && (wb_addr != 6'd0) && r_busy[wb_addr];
  assign w_wbMiss  = wb_valid && (wb_addr != 6'd0) && !r_busy[wb_addr];
  assign w_clrMask = w_wbHit ? (64'd1 << wb_addr) : 64'd0;
  assign w_postWb  = r_outstanding - {3'd0, w_wbHit};

`ifdef SCOREBOARD_BYPASS_EN
  // A register retiring this cycle no longer blocks its consumers.
  assign w_hazBusy = r_busy & ~w_clrMask;
`else
  assign w_hazBusy = r_busy;
`endif

  assign w_raw    = ((in_rs1 != 6'd0) && w_hazBusy[in_rs1]) ||
                    ((in_rs2 != 6'd0) && w_hazBusy[in_rs2]);
  assign w_waw    = (in_rd != 6'd0) && w_hazBusy[in_rd];
  assign w_struct = (in_fpu && fpu_busy) || (in_mem && mem_busy);
  assign w_cap    = (in_rd != 6'd0) && (r_outstanding == 4'(MAX_OUT));

  assign w_goDrain = (r_state == RUN) && in_valid && in_io && (r_outstanding != 4'd0);

`ifdef SCOREBOARD_BYPASS_EN
  // The I/O instruction may leave DRAIN as soon as the last write retires.
  assign w_stateOk = ((r_state == RUN) && !w_goDrain) ||
                     ((r_state == DRAIN) && in_io && (w_postWb == 4'd0));
`else
  assign w_stateOk = (r_state == RUN) && !w_goDrain;
`endif

  assign in_ready = w_stateOk && !w_raw && !w_waw && !w_struct && !w_cap && !flush && !rst;
  assign issue    = in_valid && in_ready;

  assign w_setEn   = issue && (in_rd != 6'd0);
  assign w_setMask = w_setEn ? (64'd1 << in_rd) : 64'd0;

  // Set is applied after clear so a same-register issue/writeback leaves the bit busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_busy        <= 64'd0;
      r_outstanding <= 4'd0;
      r_wbErr       <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clrMask) | w_setMask;

      case ({w_setEn, w_wbHit})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_wbMiss) begin
        r_wbErr <= 1'b1;
      end

      if (flush) begin
        r_state <= RUN;
      end else begin
        case (r_state)
          RUN:     if (w_goDrain) r_state <= DRAIN;
          DRAIN:   if (w_postWb == 4'd0) r_state <= RUN;
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign outstanding = r_outstanding;
  assign draining    = (r_state == DRAIN);
  assign wb_err      = r_wbErr;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a per-cycle vector table followed by hand-written
// sequences for dependent-issue latency and same-cycle issue/writeback.
module tb_issue_scoreboard;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [5:0] inRs1;
  logic [5:0] inRs2;
  logic [5:0] inRd;
  logic       inFpu;
  logic       inMem;
  logic       inIo;
  logic       fpuBusy;
  logic       memBusy;
  logic       wbValid;
  logic [5:0] wbAddr;
  logic       flush;
  logic       issue;
  logic [3:0] outstanding;
  logic       draining;
  logic       wbErr;

  int checks;
  int errors;

  issue_scoreboard #(.MAX_OUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .in_rs1      (inRs1),
    .in_rs2      (inRs2),
    .in_rd       (inRd),
    .in_fpu      (inFpu),
    .in_mem      (inMem),
    .in_io       (inIo),
    .fpu_busy    (fpuBusy),
    .mem_busy    (memBusy),
    .wb_valid    (wbValid),
    .wb_addr     (wbAddr),
    .flush       (flush),
    .issue       (issue),
    .outstanding (outstanding),
    .draining    (draining),
    .wb_err      (wbErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One record per clock cycle: inputs plus the outputs expected just before the edge.
  typedef struct {
    logic       rst;
    logic       vld;
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic [5:0] rd;
    logic [4:0] cls;
    logic       wbV;
    logic [5:0] wbA;
    logic       fl;
    logic       eReady;
    logic       eIssue;
    logic [3:0] eOut;
    logic       eDrain;
    logic       eErr;
  } vec_t;

  vec_t vecs[$];

  // cls bits are {fpu, mem, io, fpuBusy, memBusy}.
  task automatic addVec(input logic r, input logic v, input logic [5:0] s1, input logic [5:0] s2,
                        input logic [5:0] d, input logic [4:0] c, input logic wv,
                        input logic [5:0] wa, input logic fl, input logic er, input logic ei,
                        input logic [3:0] eo, input logic ed, input logic ee);
    vec_t t;
    t.rst = r; t.vld = v; t.rs1 = s1; t.rs2 = s2; t.rd = d; t.cls = c;
    t.wbV = wv; t.wbA = wa; t.fl = fl;
    t.eReady = er; t.eIssue = ei; t.eOut = eo; t.eDrain = ed; t.eErr = ee;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t t);
    rst     = t.rst;
    inValid = t.vld;
    inRs1   = t.rs1;
    inRs2   = t.rs2;
    inRd    = t.rd;
    inFpu   = t.cls[4];
    inMem   = t.cls[3];
    inIo    = t.cls[2];
    fpuBusy = t.cls[1];
    memBusy = t.cls[0];
    wbValid = t.wbV;
    wbAddr  = t.wbA;
    flush   = t.fl;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic driveInstr(input logic v, input logic [5:0] s1, input logic [5:0] d,
                            input logic wv, input logic [5:0] wa);
    vec_t t;
    t.rst = 1'b0; t.vld = v; t.rs1 = s1; t.rs2 = 6'd0; t.rd = d; t.cls = 5'b00000;
    t.wbV = wv; t.wbA = wa; t.fl = 1'b0;
    t.eReady = 1'b0; t.eIssue = 1'b0; t.eOut = 4'd0; t.eDrain = 1'b0; t.eErr = 1'b0;
    applyStimulus(t);
  endtask

  initial begin
    int cnt;
    int lat;
    int expLat;
    checks = 0;
    errors = 0;

    // Reset and a RAW stall on x5 resolved by its writeback.
    addVec(1, 1, 0, 0, 5, 5'b00000, 0, 0, 0,  0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 5, 5'b00000, 0, 0, 0,  1, 1, 0, 0, 0);
    addVec(0, 1, 5, 0, 6, 5'b00000, 0, 0, 0,  0, 0, 1, 0, 0);
`ifdef SCOREBOARD_BYPASS_EN
    addVec(0, 1, 5, 0, 6, 5'b00000, 1, 5, 0,  1, 1, 1, 0, 0);
    addVec(0, 1, 5, 0, 6, 5'b00000, 0, 0, 0,  0, 0, 1, 0, 0);
`else
    addVec(0, 1, 5, 0, 6, 5'b00000, 1, 5, 0,  0, 0, 1, 0, 0);
    addVec(0, 1, 5, 0, 6, 5'b00000, 0, 0, 0,  1, 1, 0, 0, 0);
`endif
    addVec(0, 0, 0, 0, 0, 5'b00000, 1, 6, 0,  1, 0, 1, 0, 0);
    // Float f1 does not block integer x1.
    addVec(0, 1, 0, 0, 33, 5'b00000, 0, 0, 0,  1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 0,  5'b00000, 0, 0, 0,  1, 1, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,  5'b00000, 1, 33, 0, 1, 0, 1, 0, 0);
    // I/O drain with three writes outstanding.
    addVec(0, 1, 0, 0, 2, 5'b00000, 0, 0, 0,  1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 3, 5'b00000, 0, 0, 0,  1, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 4, 5'b00000, 0, 0, 0,  1, 1, 2, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 0, 0, 0,  0, 0, 3, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 1, 2, 0,  0, 0, 3, 1, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 1, 3, 0,  0, 0, 2, 1, 0);
`ifdef SCOREBOARD_BYPASS_EN
    addVec(0, 1, 0, 0, 0, 5'b00100, 1, 4, 0,  1, 1, 1, 1, 0);
`else
    addVec(0, 1, 0, 0, 0, 5'b00100, 1, 4, 0,  0, 0, 1, 1, 0);
`endif
    addVec(0, 1, 0, 0, 0, 5'b00100, 0, 0, 0,  1, 1, 0, 0, 0);
    // Structural stalls.
    for (int k = 0; k < 3; k++) addVec(0, 1, 0, 0, 0, 5'b10010, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b10000, 0, 0, 0,  1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b01001, 0, 0, 0,  0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b01000, 0, 0, 0,  1, 1, 0, 0, 0);
    // Capacity: fill 15 registers, skipping x7 so it can be used for the error case.
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k != 7) begin
        addVec(0, 1, 0, 0, 6'(k), 5'b00000, 0, 0, 0, 1, 1, 4'(cnt), 0, 0);
        cnt++;
      end
    end
    addVec(0, 1, 0, 0, 20, 5'b00000, 0, 0, 0,  0, 0, 15, 0, 0);
    addVec(0, 1, 0, 0, 0,  5'b00000, 0, 0, 0,  1, 1, 15, 0, 0);
    // Writeback to a non-busy register, then reset clears the sticky error.
    addVec(0, 0, 0, 0, 0, 5'b00000, 1, 7, 0,  1, 0, 15, 0, 0);
    addVec(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,  1, 0, 15, 0, 1);
    addVec(1, 1, 0, 0, 0, 5'b00000, 0, 0, 0,  0, 0, 15, 0, 1);
    addVec(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,  1, 0, 0, 0, 0);
    // Flush out of DRAIN keeps the count, then reset from DRAIN.
    addVec(0, 1, 0, 0, 2, 5'b00000, 0, 0, 0,  1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 3, 5'b00000, 0, 0, 0,  1, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 0, 0, 0,  0, 0, 2, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 0, 0, 1,  0, 0, 2, 1, 0);
    addVec(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0,  1, 0, 2, 0, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 0, 0, 0,  0, 0, 2, 0, 0);
    addVec(1, 1, 0, 0, 0, 5'b00100, 0, 0, 0,  0, 0, 2, 1, 0);
    addVec(0, 1, 0, 0, 0, 5'b00100, 0, 0, 0,  1, 1, 0, 0, 0);

    applyStimulus(vecs[0]);
    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.in_ready", i),    int'(inReady),     int'(vecs[i].eReady));
      checkOutput($sformatf("v%0d.issue", i),       int'(issue),       int'(vecs[i].eIssue));
      checkOutput($sformatf("v%0d.outstanding", i), int'(outstanding), int'(vecs[i].eOut));
      checkOutput($sformatf("v%0d.draining", i),    int'(draining),    int'(vecs[i].eDrain));
      checkOutput($sformatf("v%0d.wb_err", i),      int'(wbErr),       int'(vecs[i].eErr));
      @(negedge clk);
    end

    // Dependent-issue latency measured from the producer's writeback cycle.
    driveInstr(1, 0, 10, 0, 0);
    #1;
    checkOutput("seq.prodIssue", int'(issue), 1);
    step();
    driveInstr(1, 10, 0, 0, 0);
    #1;
    checkOutput("seq.rawStall0", int'(inReady), 0);
    step();
    #1;
    checkOutput("seq.rawStall1", int'(inReady), 0);
    wbValid = 1'b1;
    wbAddr  = 6'd10;
    #1;
    lat = 0;
    if (issue == 1'b0) begin
      step();
      wbValid = 1'b0;
      #1;
      lat = 1;
      while (issue == 1'b0 && lat < 5) begin
        step();
        #1;
        lat++;
      end
    end
`ifdef SCOREBOARD_BYPASS_EN
    expLat = 0;
`else
    expLat = 1;
`endif
    checkOutput("seq.depLatency", lat, expLat);
    step();
    driveInstr(0, 0, 0, 0, 0);
    #1;
    checkOutput("seq.outAfterDep", int'(outstanding), 0);

    // Issue of x13 in the same cycle as the writeback of x12.
    driveInstr(1, 0, 12, 0, 0);
    step();
    driveInstr(1, 0, 13, 1, 12);
    #1;
    checkOutput("seq.sameCycIssue", int'(issue), 1);
    checkOutput("seq.sameCycOutPre", int'(outstanding), 1);
    step();
    driveInstr(1, 0, 13, 0, 0);
    #1;
    checkOutput("seq.sameCycOutPost", int'(outstanding), 1);
    checkOutput("seq.wawStall", int'(inReady), 0);
    driveInstr(1, 0, 12, 0, 0);
    #1;
    checkOutput("seq.clearedReg", int'(inReady), 1);
    driveInstr(0, 0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between the instruction decoder and the execution units. It tracks pending register writes across the 64-entry unified register space: 32 integer registers plus 32 float registers, selected by address bit 5. Each decoded instruction is held until it is free of RAW hazards, WAW hazards, structural hazards (FPU or memory unit) and the I/O serialization rule. Only then is it released to execute.

## Interface
Parameters:
- `MAX_OUT`, default 15: maximum outstanding register writes; the outstanding counter is 4 bits wide.

Ports (reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  instruction issues this cycle when `in_valid & in_ready`
- `in_rs1`, `in_rs2`, `in_rd`  in  6 each  decoder register addresses; 6'd0 means unused
- `in_fpu`, `in_mem`, `in_io`  in  1 each  unit class flags from the decoder
- `fpu_busy`, `mem_busy`  in  1 each  unit cannot accept an operation this cycle
- `wb_valid`  in  1  a register write completes this cycle
- `wb_addr`  in  6  register written
- `flush`  in  1  drop the held instruction and return to RUN
- `issue`  out  1  equals `in_valid & in_ready`
- `outstanding`  out  4  count of busy registers
- `draining`  out  1  FSM is in DRAIN
- `wb_err`  out  1  sticky flag: writeback to a non-busy register

## Operation
- State: `busy[63:0]`, `outstanding` counter, FSM {RUN, DRAIN}, `wb_err`.
- Address 0 is never busy. Sources or destinations equal to 0 never cause a hazard.
- Hazards, evaluated against the current `busy` value:
  - RAW: `busy[in_rs1]` or `busy[in_rs2]`.
  - WAW: `busy[in_rd]`.
  - Structural: (`in_fpu & fpu_busy`) or (`in_mem & mem_busy`).
  - Capacity: `in_rd != 0` and `outstanding == MAX_OUT`.
- `in_ready` is 1 only when all of the following hold: state is RUN, no hazard, `flush` is 0, and `rst` is 0.
- I/O serialization: if state is RUN, `in_valid & in_io` is asserted, and `outstanding != 0`, the FSM goes to DRAIN and `in_ready` = 0.
  - In DRAIN, `in_ready` = 0.
  - The FSM returns to RUN on the cycle after the post-update `outstanding` reaches 0. The I/O instruction then issues from RUN.
- On issue with `in_rd != 0`: set `busy[in_rd]` and increment `outstanding`.
- On `wb_valid` with `wb_addr != 0`:
  - If `busy[wb_addr]` is set, clear it and decrement `outstanding`.
  - Otherwise set `wb_err`. `busy` and `outstanding` are unchanged.
- Issue and writeback in the same cycle:
  - Different registers: both take effect.
  - Same register (possible only with bypass): set wins, and `outstanding` is unchanged net.
- `flush`: the FSM goes to RUN and nothing issues that cycle. `busy` and `outstanding` are NOT cleared, because in-flight writes still complete.

## Timing
- Reset values: `busy` = 0, `outstanding` = 0, FSM = RUN, `wb_err` = 0. Outputs during reset: `in_ready` = 0, `issue` = 0, `draining` = 0.
- `in_ready` and `issue` are combinational from the inputs and the registered state, with zero-cycle issue latency.
- `busy`, `outstanding`, the FSM and `wb_err` update on the rising edge of `clk`.
- Without bypass, a dependent instruction issues at the earliest one cycle after the `wb_valid` of its source.
- The decoder must hold its inputs stable while `in_valid & ~in_ready`.
- Reset mid-operation, including in DRAIN, takes every register to its reset value regardless of any other input.

## Configuration
- `SCOREBOARD_BYPASS_EN` defined: a writeback in the current cycle is masked out of the hazard check. An instruction whose RAW or WAW hazard is only on `wb_addr` issues in the same cycle as that writeback. The DRAIN exit may use the same-cycle decrement, with `in_ready` asserted in DRAIN when the post-writeback count is 0 and `in_io` is set.
- `SCOREBOARD_BYPASS_EN` undefined: hazards use the registered `busy` only, which costs one bubble per dependent writeback.

## Test plan
- Reset, then issue `rd`=6'd5. Next cycle present `rs1`=6'd5: `in_ready` = 0. Pulse `wb_valid`, `wb_addr`=5: `issue` rises the cycle after, or the same cycle when `SCOREBOARD_BYPASS_EN` is defined. `outstanding` goes 1 → 0 → 1.
- Float/integer separation: issue `rd`=6'd33 (f1), then present `rs1`=6'd1 (x1): the instruction issues immediately with no stall.
- I/O drain: three writes outstanding (`rd`=2,3,4), then `in_io`=1: `draining` = 1. Retire one writeback per cycle: `draining` falls after the third writeback, and the I/O instruction issues with `outstanding` = 0.
- Structural and capacity stalls:
  - `in_fpu`=1 with `fpu_busy`=1 for 3 cycles: no issue for those 3 cycles, then issue.
  - Fill `outstanding` to 15: a 16th instruction with `rd`=6'd20 stalls, while an instruction with `rd`=0 (a store) issues.
- Writeback to non-busy register 7: `wb_err` = 1 and stays set. `outstanding` is unchanged. Asserting `rst` clears `wb_err`.
- `flush` asserted while in DRAIN with 2 writes outstanding: FSM returns to RUN, `outstanding` stays 2, and `issue` = 0 in the flush cycle.
